// File: rtl/vscale_regfile_ctrl.sv
// Regfile front end: zeroes x1..x31 after reset while stalling the core, then
// shares the write port and read port 2 between the core and a debug host.
module vscale_regfile_ctrl #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      core_wen,
    input  logic [REG_ADDR_WIDTH-1:0] core_wa,
    input  logic [XPR_LEN-1:0]        core_wd,
    input  logic [REG_ADDR_WIDTH-1:0] core_ra2,
    input  logic                      core_ra2_used,
    output logic                      core_stall,
    input  logic                      dbg_req,
    input  logic                      dbg_we,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [XPR_LEN-1:0]        dbg_wdata,
    output logic                      dbg_gnt,
    output logic                      dbg_rvalid,
    output logic [XPR_LEN-1:0]        dbg_rdata,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_wa,
    output logic [XPR_LEN-1:0]        rf_wd,
    output logic [REG_ADDR_WIDTH-1:0] rf_ra2,
    input  logic [XPR_LEN-1:0]        rf_rd2,
    output logic                      init_busy
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG   = {REG_ADDR_WIDTH{1'b1}};
    localparam logic [REG_ADDR_WIDTH-1:0] FIRST_REG  = {{(REG_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]                STARVE_MAX = 8'(STARVE_LIMIT);

    state_e                    state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [7:0]                starve_cnt_q, starve_cnt_d;
    logic                      starve_stall_q, starve_stall_d;
    logic                      dbg_rvalid_q, dbg_rvalid_d;
    logic [XPR_LEN-1:0]        dbg_rdata_q, dbg_rdata_d;
    logic                      rf_wen_s;
    logic                      core_wr_s;
    logic                      dbg_wr_gnt_s;
    logic                      dbg_rd_gnt_s;

    // Next-state, arbitration and regfile port steering
    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        starve_cnt_d   = 8'd0;
        starve_stall_d = 1'b0;
        dbg_rvalid_d   = 1'b0;
        dbg_rdata_d    = dbg_rdata_q;
        init_busy      = 1'b0;
        core_stall     = 1'b0;
        core_wr_s      = 1'b0;
        dbg_wr_gnt_s   = 1'b0;
        dbg_rd_gnt_s   = 1'b0;
        dbg_gnt        = 1'b0;
        rf_wen_s       = 1'b0;
        rf_wa          = core_wa;
        rf_wd          = core_wd;
        rf_ra2         = core_ra2;
        case (state_q)
            ST_INIT: begin
                init_busy  = 1'b1;
                core_stall = 1'b1;
                rf_wen_s   = 1'b1;
                rf_wa      = init_cnt_q;
                rf_wd      = {XPR_LEN{1'b0}};
                init_cnt_d = init_cnt_q + FIRST_REG;
                if (init_cnt_q == LAST_REG) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                core_stall   = starve_stall_q;
                core_wr_s    = core_wen & ~starve_stall_q;
                dbg_wr_gnt_s = dbg_req & dbg_we & ~core_wr_s;
                dbg_rd_gnt_s = dbg_req & ~dbg_we & (~core_ra2_used | starve_stall_q);
                dbg_gnt      = dbg_wr_gnt_s | dbg_rd_gnt_s;
                if (core_wr_s) begin
                    rf_wen_s = 1'b1;
                end else if (dbg_wr_gnt_s) begin
                    rf_wen_s = 1'b1;
                    rf_wa    = dbg_addr;
                    rf_wd    = dbg_wdata;
                end else begin
                    rf_wen_s = 1'b0;
                end
                if (dbg_rd_gnt_s) begin
                    rf_ra2       = dbg_addr;
                    dbg_rvalid_d = 1'b1;
                    dbg_rdata_d  = rf_rd2;
                end else begin
                    rf_ra2       = core_ra2;
                end
                // Saturating wait count; a forced stall follows the cycle it hits the limit
                if (dbg_req && !dbg_gnt) begin
                    if (starve_cnt_q != 8'hFF) begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else begin
                    starve_cnt_d = 8'd0;
                end
                starve_stall_d = (starve_cnt_d == STARVE_MAX);
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign rf_wen     = rf_wen_s & ~rst;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

    // State and handshake registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            init_cnt_q     <= FIRST_REG;
            starve_cnt_q   <= 8'd0;
            starve_stall_q <= 1'b0;
            dbg_rvalid_q   <= 1'b0;
            dbg_rdata_q    <= {XPR_LEN{1'b0}};
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            starve_cnt_q   <= starve_cnt_d;
            starve_stall_q <= starve_stall_d;
            dbg_rvalid_q   <= dbg_rvalid_d;
            dbg_rdata_q    <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_vscale_regfile_ctrl.sv
// Bench for vscale_regfile_ctrl: randomized core/debug traffic against a
// register-level reference model, with a scoreboard for debug read data.
module tb_vscale_regfile_ctrl;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_wen = 1'b0, core_ra2_used = 1'b0;
    logic [4:0]  core_wa = 5'd0, core_ra2 = 5'd0;
    logic [31:0] core_wd = 32'd0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_wdata = 32'd0;
    logic        core_stall, dbg_gnt, dbg_rvalid, rf_wen, init_busy;
    logic [31:0] dbg_rdata, rf_wd, rf_rd2;
    logic [4:0]  rf_wa, rf_ra2;

    vscale_regfile_ctrl #(.XPR_LEN(32), .REG_ADDR_WIDTH(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_wen(core_wen), .core_wa(core_wa), .core_wd(core_wd),
        .core_ra2(core_ra2), .core_ra2_used(core_ra2_used), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra2(rf_ra2), .rf_rd2(rf_rd2),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Regfile stand-in: no reset (seeded with garbage), x0 reads as zero
    logic [31:0] mem [32];
    bit          mem_seeded = 1'b0;
    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < 32; i++) mem[i] <= $urandom;
            mem_seeded <= 1'b1;
        end else if (rf_wen && rf_wa != 5'd0) begin
            mem[rf_wa] <= rf_wd;
        end
    end
    assign rf_rd2 = (rf_ra2 == 5'd0) ? 32'd0 : mem[rf_ra2];

    int          n_vec = 0, n_err = 0;
    logic [31:0] shadow [32];
    logic [31:0] exp_q [$];
    logic [31:0] m_rdata = 32'd0;
    int          m_cyc = 0, m_wait = 0;
    bit          m_force = 1'b0, m_known = 1'b0;
    logic [1:0]  core_mode = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: evaluated mid-cycle, then advanced past the edge
    always @(negedge clk) begin
        logic exp_gnt, core_w;
        if (m_known) begin
            chk("rvalid", 32'(dbg_rvalid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
            chk("rdata", dbg_rdata, m_rdata);
        end
        if (rst) begin
            if (m_known) chk("rst_wen", 32'(rf_wen), 32'd0);
            m_known = 1'b1; m_cyc = 0; m_wait = 0; m_force = 1'b0;
            exp_q.delete(); m_rdata = 32'd0;
        end else if (m_known && m_cyc < 31) begin
            chk("init_busy", 32'(init_busy), 32'd1);
            chk("init_stall", 32'(core_stall), 32'd1);
            chk("init_gnt", 32'(dbg_gnt), 32'd0);
            chk("init_wen", 32'(rf_wen), 32'd1);
            chk("init_wa", 32'(rf_wa), 32'(m_cyc + 1));
            chk("init_wd", rf_wd, 32'd0);
            shadow[m_cyc + 1] = 32'd0;
            m_cyc++;
        end else if (m_known) begin
            exp_gnt = dbg_req && (m_force || (dbg_we ? !core_wen : !core_ra2_used));
            core_w  = core_wen && !m_force;
            chk("run_busy", 32'(init_busy), 32'd0);
            chk("core_stall", 32'(core_stall), 32'(m_force));
            chk("dbg_gnt", 32'(dbg_gnt), 32'(exp_gnt));
            if (core_w) begin
                chk("core_wen", 32'(rf_wen), 32'd1);
                chk("core_wa", 32'(rf_wa), 32'(core_wa));
                chk("core_wd", rf_wd, core_wd);
            end else if (exp_gnt && dbg_we) begin
                chk("dbg_wen", 32'(rf_wen), 32'd1);
                chk("dbg_wa", 32'(rf_wa), 32'(dbg_addr));
                chk("dbg_wd", rf_wd, dbg_wdata);
            end else begin
                chk("idle_wen", 32'(rf_wen), 32'd0);
            end
            chk("rf_ra2", 32'(rf_ra2), 32'((exp_gnt && !dbg_we) ? dbg_addr : core_ra2));
            if (exp_gnt && !dbg_we)
                exp_q.push_back((dbg_addr == 5'd0) ? 32'd0 : shadow[dbg_addr]);
            if (core_w && core_wa != 5'd0) shadow[core_wa] = core_wd;
            else if (exp_gnt && dbg_we && dbg_addr != 5'd0) shadow[dbg_addr] = dbg_wdata;
            m_force = 1'b0;
            if (dbg_req && !exp_gnt) begin
                m_wait++;
                if (m_wait == LIMIT) m_force = 1'b1;
            end else begin
                m_wait = 0;
            end
        end
    end

    task automatic core_step();
        case (core_mode)
            2'd1: begin
                core_wen      = 1'($urandom_range(0, 1));
                core_wa       = 5'($urandom);
                core_wd       = $urandom;
                core_ra2      = 5'($urandom);
                core_ra2_used = 1'($urandom_range(0, 1));
            end
            2'd2: begin
                core_wen      = 1'b0;
                core_ra2_used = 1'b1;
                core_ra2      = 5'($urandom);
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        core_step();
    endtask

    task automatic core_idle();
        core_mode = 2'd0; core_wen = 1'b0; core_ra2_used = 1'b0;
        core_wa = 5'd0; core_ra2 = 5'd0; core_wd = 32'd0;
    endtask

    task automatic dbg_access(input bit we, input logic [4:0] addr, input logic [31:0] data,
                              output int waited);
        bit got = 1'b0;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
        waited = 0;
        while (!got && waited < 64) begin
            #2;
            waited++;
            got = dbg_gnt;
            tick();
        end
        dbg_req = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL dbg_timeout: addr %0d got no grant, required one within %0d cycles",
                     addr, LIMIT + 1);
        end
    endtask

    initial begin
        int w;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        repeat (31) tick();
        for (int i = 1; i < 32; i++) dbg_access(1'b0, 5'(i), 32'd0, w);

        dbg_access(1'b1, 5'd5, 32'hDEADBEEF, w);
        chk("idle_gnt_cycles", 32'(w), 32'd1);
        dbg_access(1'b0, 5'd5, 32'd0, w);

        core_wen = 1'b1; core_wa = 5'd7; core_wd = 32'hA5A50007;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h09090909;
        tick();
        core_wen = 1'b0;
        tick();
        dbg_req = 1'b0;
        dbg_access(1'b0, 5'd7, 32'd0, w);
        dbg_access(1'b0, 5'd9, 32'd0, w);

        core_mode = 2'd2;
        tick();
        dbg_access(1'b0, 5'd3, 32'd0, w);
        chk("starve_cycles", 32'(w), 32'(LIMIT + 1));
        core_idle();

        dbg_access(1'b1, 5'd0, 32'h00001234, w);
        dbg_access(1'b0, 5'd0, 32'd0, w);

        core_mode = 2'd1;
        repeat (40) begin
            dbg_access(1'($urandom_range(0, 1)), 5'($urandom), $urandom, w);
            chk("wait_bound", 32'(w <= LIMIT + 1), 32'd1);
            if ($urandom_range(0, 2) == 0) tick();
        end
        core_idle();
        tick();

        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5; rst = 1'b1;
        tick();
        rst = 1'b0; dbg_req = 1'b0;
        repeat (16) tick();
        #2;
        chk("init_cnt_17", 32'(rf_wa), 32'd17);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (31) tick();
        dbg_access(1'b0, 5'd5, 32'd0, w);
        dbg_access(1'b0, 5'd31, 32'd0, w);

        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vscale_regfile_ctrl.md
# vscale_regfile_ctrl

Sequencer and port arbiter in front of `vscale_regfile`. The register file has no reset, so after reset this block zeroes x1..x31 through the write port and stalls the core until that finishes. From then on it shares write port and read port 2 between the core pipeline and a debug host. The core has priority, and a starvation counter bounds how long the debug host waits. It sits between the pipeline's writeback/decode stages and the regfile instance.

## Interface

Parameters:
- `XPR_LEN`, 32, data width.
- `REG_ADDR_WIDTH`, 5, register address width (32 registers).
- `STARVE_LIMIT`, 8, number of consecutive ungranted debug-request cycles before a forced core stall. Legal range 1..255.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `core_wen` in 1: core writeback enable.
- `core_wa` in `REG_ADDR_WIDTH`: core write address.
- `core_wd` in `XPR_LEN`: core write data.
- `core_ra2` in `REG_ADDR_WIDTH`: core read address for port 2.
- `core_ra2_used` in 1: core needs read port 2 this cycle.
- `core_stall` out 1: core must hold its state and issue no regfile access this cycle.
- `dbg_req` in 1: debug access request. Held high with stable fields until granted.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in `REG_ADDR_WIDTH`: debug register address.
- `dbg_wdata` in `XPR_LEN`: debug write data.
- `dbg_gnt` out 1: debug access performed this cycle (combinational).
- `dbg_rvalid` out 1: registered pulse, read data valid.
- `dbg_rdata` out `XPR_LEN`: read data, held until the next read completes.
- `rf_wen`, `rf_wa`, `rf_wd` out 1 / `REG_ADDR_WIDTH` / `XPR_LEN`: to regfile write port.
- `rf_ra2` out `REG_ADDR_WIDTH`: to regfile read address 2.
- `rf_rd2` in `XPR_LEN`: from regfile read data 2.
- `init_busy` out 1: zeroing sequence in progress.

## Operation

- State machine: INIT → RUN. `rst` forces INIT from any state with `init_cnt`=1, `starve_cnt`=0, `dbg_rvalid`=0, `dbg_rdata`=0.
- INIT state:
  - `rf_wen`=1, `rf_wa`=`init_cnt`, `rf_wd`=0, `init_busy`=1, `core_stall`=1, `dbg_gnt`=0.
  - `init_cnt` increments each cycle. On the cycle with `init_cnt`=31 the state moves to RUN.
- While `rst` is high, `rf_wen` is forced to 0.
- RUN state, write port:
  - If `core_stall`=0 and `core_wen`=1, the core owns the port and `rf_*` = `core_*`.
  - Otherwise a pending debug write is granted and drives `rf_wen`=1, `rf_wa`=`dbg_addr`, `rf_wd`=`dbg_wdata`.
- RUN state, read port 2:
  - `rf_ra2`=`core_ra2` unless a debug read is granted; in that case `rf_ra2`=`dbg_addr`.
  - A debug read is granted when `core_ra2_used`=0 or `core_stall`=1.
- Starvation counter:
  - `starve_cnt` increments on each RUN cycle with `dbg_req`=1 and `dbg_gnt`=0. It clears on grant or when `dbg_req`=0.
  - When `starve_cnt` reaches `STARVE_LIMIT`, a registered `starve_stall` is set for exactly one cycle, during which the debug request is granted unconditionally.
  - `core_stall` = `init_busy` | `starve_stall`.
- Debug address 0:
  - Write: granted normally; the regfile discards it.
  - Read: granted normally and returns 0 (regfile behaviour).
- At most one debug access per grant. `dbg_gnt` is never asserted while `dbg_req`=0.

## Timing

- Reset values (first cycle after `rst` falls):
  - `init_busy`=1, `core_stall`=1, `rf_wen`=1, `rf_wa`=1, `rf_wd`=0.
  - `dbg_gnt`=0, `dbg_rvalid`=0, `dbg_rdata`=0.
- INIT lasts exactly 31 cycles: x1..x31 are written in order. The first RUN cycle is cycle 32 after reset deassertion.
- `dbg_gnt` is combinational, so a grant can occur in the same cycle as the request.
- Write latency: the register is updated at the clock edge ending the grant cycle.
- Read latency: `dbg_rdata` is captured from `rf_rd2` at the end of the grant cycle. `dbg_rvalid`=1 for one cycle on the next cycle.
- Worst-case debug wait is `STARVE_LIMIT`+1 cycles from request to grant in RUN.
- A `rst` asserted mid-INIT or mid-access aborts it:
  - A pending `dbg_rvalid` is suppressed.
  - Zeroing restarts at x1.

## Test plan

- **Reset/INIT:** pulse `rst` for 2 cycles → `rf_wen`=1 for 31 cycles with `rf_wa` = 1,2,…,31 and `rf_wd`=0; `init_busy`/`core_stall` drop on cycle 32; all registers read 0.
- **Idle debug write then read:** `dbg_req`=1, `dbg_we`=1, `dbg_addr`=5, `dbg_wdata`=0xDEADBEEF with core idle → `dbg_gnt` same cycle. A following read of x5 → `dbg_rvalid` next cycle with `dbg_rdata`=0xDEADBEEF.
- **Core priority:** `core_wen`=1 with `core_wa`=7 and a debug write to x9 in the same cycle → x7 is written and `dbg_gnt`=0. In the next idle cycle the debug write is granted.
- **Starvation (`STARVE_LIMIT`=8):** hold `core_ra2_used`=1 continuously and issue a debug read of x3 → `core_stall`=1 for exactly one cycle after 8 ungranted cycles. `dbg_gnt` is asserted in that cycle and `starve_cnt` returns to 0.
- **x0 access:** debug write 0x1234 to x0, then read x0 → `dbg_rdata`=0.
- **Reset mid-operation:** assert `rst` at INIT `init_cnt`=17, and separately on a debug-read grant cycle → INIT restarts at `rf_wa`=1 and no `dbg_rvalid` appears.
